// File: rtl/fetch_redirect_if.sv
// fetch_redirect_if: fetch-side bus between the redirect controller and its pipeline neighbours.
interface fetch_redirect_if #(
    parameter int size = 32
) ();
    logic            stall_i;
    logic            inst_valid_i;
    logic [size-1:0] inst_i;
    logic [size-1:0] pc_o;
    logic            fetch_valid_o;
    logic            predicted_taken_o;
    logic            flush_o;
    logic            ex_resolve_valid_i;
    logic            ex_is_branch_i;
    logic            ex_jalr_i;
    logic            ex_taken_i;
    logic            ex_mispredict_i;
    logic [size-1:0] ex_pc_i;
    logic [size-1:0] ex_target_i;

    modport master (
        output stall_i, inst_valid_i, inst_i,
        output ex_resolve_valid_i, ex_is_branch_i, ex_jalr_i, ex_taken_i, ex_mispredict_i, ex_pc_i, ex_target_i,
        input  pc_o, fetch_valid_o, predicted_taken_o, flush_o
    );

    modport slave (
        input  stall_i, inst_valid_i, inst_i,
        input  ex_resolve_valid_i, ex_is_branch_i, ex_jalr_i, ex_taken_i, ex_mispredict_i, ex_pc_i, ex_target_i,
        output pc_o, fetch_valid_o, predicted_taken_o, flush_o
    );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: owns the fetch PC, predicts JAL/B-type targets, sequences JALR wait and mispredict flush.
// Macro BHT_EN adds a 2-bit saturating-counter branch history table; otherwise every B-type is predicted taken.
module fetch_redirect_ctrl #(
    parameter int              size         = 32,
    parameter logic [size-1:0] RESET_VECTOR = '0,
    parameter int              FLUSH_CYCLES = 2,
    parameter int              BHT_ENTRIES  = 64
) (
    input logic             clk,
    input logic             rst_n,
    fetch_redirect_if.slave bus
);
    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {BOOT, RUN, JALR_WAIT, FLUSH} state_t;

    state_t          state_q, state_d;
    logic [size-1:0] pc_q, pc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [size-1:0] imm_j, imm_b;
    logic            is_jal, is_br, is_jalr, br_taken, mispred, fire, jalr_done;
    logic            unused_ex;

    assign is_jal  = bus.inst_i[6:0] == 7'b1101111;
    assign is_br   = bus.inst_i[6:0] == 7'b1100011;
    assign is_jalr = bus.inst_i[6:0] == 7'b1100111;
    assign imm_j   = {{(size-20){bus.inst_i[31]}}, bus.inst_i[19:12], bus.inst_i[20], bus.inst_i[30:21], 1'b0};
    assign imm_b   = {{(size-12){bus.inst_i[31]}}, bus.inst_i[7], bus.inst_i[30:25], bus.inst_i[11:8], 1'b0};

`ifdef BHT_EN
    localparam int IW = $clog2(BHT_ENTRIES);
    logic [1:0]    bht_q [BHT_ENTRIES];
    logic [IW-1:0] rd_idx, wr_idx;
    logic [1:0]    wr_ctr;
    assign rd_idx   = pc_q[IW+1:2];
    assign wr_idx   = bus.ex_pc_i[IW+1:2];
    assign wr_ctr   = bht_q[wr_idx];
    assign br_taken = bht_q[rd_idx][1];
    // Lookup reads the registered array, so a same-cycle update to the same index is not seen.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b10;
        end else if (bus.ex_resolve_valid_i && bus.ex_is_branch_i) begin
            bht_q[wr_idx] <= bus.ex_taken_i ? ((wr_ctr == 2'b11) ? wr_ctr : wr_ctr + 2'b01)
                                            : ((wr_ctr == 2'b00) ? wr_ctr : wr_ctr - 2'b01);
        end
    end
`else
    assign br_taken = 1'b1;
`endif

    assign unused_ex = ^{bus.ex_pc_i, bus.ex_is_branch_i, bus.ex_taken_i};

    assign mispred   = bus.ex_resolve_valid_i && bus.ex_mispredict_i && state_q != BOOT;
    assign fire      = state_q == RUN && bus.inst_valid_i && !bus.stall_i && !mispred;
    assign jalr_done = bus.ex_resolve_valid_i && bus.ex_jalr_i;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        if (mispred) begin
            state_d = FLUSH;
            pc_d    = bus.ex_target_i;
            cnt_d   = CW'(FLUSH_CYCLES - 1);
        end else begin
            case (state_q)
                BOOT: state_d = RUN;
                RUN: begin
                    state_d = (fire && is_jalr) ? JALR_WAIT : RUN;
                    pc_d    = (!fire || is_jalr) ? pc_q
                            : pc_q + (is_jal ? imm_j : (is_br && br_taken) ? imm_b : size'(4));
                end
                JALR_WAIT: begin
                    state_d = jalr_done ? RUN : JALR_WAIT;
                    pc_d    = jalr_done ? bus.ex_target_i : pc_q;
                end
                FLUSH: begin
                    state_d = (cnt_q == '0) ? RUN : FLUSH;
                    cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
                end
                default: state_d = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.pc_o              = pc_q;
    assign bus.fetch_valid_o     = state_q == RUN;
    assign bus.flush_o           = state_q == FLUSH;
    assign bus.predicted_taken_o = fire && (is_jal || (is_br && br_taken));
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb_fetch_redirect_ctrl: directed plus randomized stimulus against a behavioural fetch model.
// Instructions are built from chosen immediates, so the model never decodes instruction bits.
module tb_fetch_redirect_ctrl;
    localparam int FLUSH = 2;
    localparam int K_NOP = 0, K_JAL = 1, K_BR = 2, K_JALR = 3, K_ALU = 4;

    logic clk, rst_n;
    int   n_cmp = 0, n_bad = 0;

    // Reference model: mode 0 boot, 1 run, 2 waiting on JALR, 3 flushing
    int          mode;
    logic [31:0] m_pc;
    int          flush_left;
    int          ctr [64];
    int          cur_kind;
    int          cur_imm;

    fetch_redirect_if #(.size(32)) bus ();

    fetch_redirect_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic m_br_pred();
`ifdef BHT_EN
        return ctr[m_pc[7:2]] >= 2;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic m_pt();
        logic mp;
        mp = bus.ex_resolve_valid_i && bus.ex_mispredict_i && mode != 0;
        return mode == 1 && bus.inst_valid_i && !bus.stall_i && !mp
               && (cur_kind == K_JAL || (cur_kind == K_BR && m_br_pred()));
    endfunction

    task automatic model_edge();
        logic mp, pred;
        if (!rst_n) begin
            mode = 0; m_pc = 32'h0; flush_left = 0;
            foreach (ctr[i]) ctr[i] = 2;
            return;
        end
        mp   = bus.ex_resolve_valid_i && bus.ex_mispredict_i && mode != 0;
        pred = m_br_pred();
        if (mp) begin
            m_pc = bus.ex_target_i; mode = 3; flush_left = FLUSH;
        end else if (mode == 0) begin
            mode = 1;
        end else if (mode == 2) begin
            if (bus.ex_resolve_valid_i && bus.ex_jalr_i) begin m_pc = bus.ex_target_i; mode = 1; end
        end else if (mode == 3) begin
            flush_left--;
            if (flush_left == 0) mode = 1;
        end else if (bus.inst_valid_i && !bus.stall_i) begin
            case (cur_kind)
                K_JALR:  mode = 2;
                K_JAL:   m_pc = m_pc + 32'(cur_imm);
                K_BR:    m_pc = m_pc + (pred ? 32'(cur_imm) : 32'd4);
                default: m_pc = m_pc + 32'd4;
            endcase
        end
`ifdef BHT_EN
        if (bus.ex_resolve_valid_i && bus.ex_is_branch_i) begin
            int k;
            k = int'(bus.ex_pc_i[7:2]);
            ctr[k] = bus.ex_taken_i ? ((ctr[k] < 3) ? ctr[k] + 1 : 3) : ((ctr[k] > 0) ? ctr[k] - 1 : 0);
        end
`endif
    endtask

    task automatic step();
        #1;
        check("pred_taken", 32'(bus.predicted_taken_o), 32'(m_pt()));
        @(posedge clk);
        model_edge();
        #1;
        check("pc", bus.pc_o, m_pc);
        check("fetch_valid", 32'(bus.fetch_valid_o), 32'(mode == 1));
        check("flush", 32'(bus.flush_o), 32'(mode == 3));
    endtask

    task automatic set_nop();
        cur_kind = K_NOP; bus.inst_i = 32'h0000_0013;
    endtask

    task automatic set_jal(int imm);
        logic [31:0] u;
        u = imm; cur_kind = K_JAL; cur_imm = imm;
        bus.inst_i = {u[20], u[10:1], u[11], u[19:12], 5'($urandom), 7'b1101111};
    endtask

    task automatic set_br(int imm);
        logic [31:0] u;
        u = imm; cur_kind = K_BR; cur_imm = imm;
        bus.inst_i = {u[12], u[10:5], 13'($urandom), u[4:1], u[11], 7'b1100011};
    endtask

    task automatic set_jalr();
        cur_kind = K_JALR; bus.inst_i = {25'($urandom), 7'b1100111};
    endtask

    task automatic set_rand_inst();
        case ($urandom_range(0, 9))
            0, 1, 2: set_jal((int'($urandom_range(0, 1048575)) - 524288) * 2);
            3, 4, 5: set_br((int'($urandom_range(0, 4095)) - 2048) * 2);
            6:       set_jalr();
            7:       begin cur_kind = K_ALU; bus.inst_i = {25'($urandom), 7'b0110011}; end
            default: set_nop();
        endcase
    endtask

    task automatic idle();
        bus.stall_i = 0; bus.inst_valid_i = 1; set_nop();
        bus.ex_resolve_valid_i = 0; bus.ex_is_branch_i = 0; bus.ex_jalr_i = 0;
        bus.ex_taken_i = 0; bus.ex_mispredict_i = 0; bus.ex_pc_i = '0; bus.ex_target_i = '0;
    endtask

    task automatic redirect(logic [31:0] t);
        idle();
        bus.ex_resolve_valid_i = 1; bus.ex_mispredict_i = 1; bus.ex_target_i = t;
        step();
        idle();
        step();
        step();
    endtask

    task automatic resolve_branch(logic [31:0] pc, logic taken);
        idle();
        bus.inst_valid_i = 0;
        bus.ex_resolve_valid_i = 1; bus.ex_is_branch_i = 1; bus.ex_taken_i = taken; bus.ex_pc_i = pc;
        step();
    endtask

    initial begin
        rst_n = 0;
        idle();
        @(posedge clk);
        model_edge();
        step();
        check("rst_pc", bus.pc_o, 32'h0);
        check("rst_valid", 32'(bus.fetch_valid_o), 32'h0);
        check("rst_flush", 32'(bus.flush_o), 32'h0);

        rst_n = 1;
        step();
        check("boot_pc", bus.pc_o, 32'h0);
        check("boot_valid", 32'(bus.fetch_valid_o), 32'h1);
        step();
        check("seq_pc4", bus.pc_o, 32'h4);
        step();
        check("seq_pc8", bus.pc_o, 32'h8);

        redirect(32'h100);
        set_jal(-8);
        #1 check("jal_pt", 32'(bus.predicted_taken_o), 32'h1);
        step();
        check("jal_pc", bus.pc_o, 32'hF8);
        redirect(32'hFFFF_FFFC);
        set_nop();
        step();
        check("wrap_pc", bus.pc_o, 32'h0);

        redirect(32'h20);
        set_jalr();
        step();
        for (int i = 0; i < 5; i++) begin
            set_rand_inst();
            step();
            check("jalr_hold_pc", bus.pc_o, 32'h20);
            check("jalr_hold_valid", 32'(bus.fetch_valid_o), 32'h0);
            check("jalr_no_flush", 32'(bus.flush_o), 32'h0);
        end
        idle();
        bus.ex_resolve_valid_i = 1; bus.ex_jalr_i = 1; bus.ex_target_i = 32'h400;
        step();
        check("jalr_pc", bus.pc_o, 32'h400);
        check("jalr_valid", 32'(bus.fetch_valid_o), 32'h1);
        check("jalr_flush", 32'(bus.flush_o), 32'h0);

        for (int pass = 0; pass < 2; pass++) begin
            redirect(32'h200);
            idle();
            bus.stall_i = 1; bus.ex_resolve_valid_i = 1; bus.ex_mispredict_i = 1; bus.ex_target_i = 32'h80;
            step();
            check("stall_mp_pc", bus.pc_o, 32'h80);
            check("stall_mp_flush1", 32'(bus.flush_o), 32'h1);
            idle();
            if (pass == 1) begin
                bus.ex_resolve_valid_i = 1; bus.ex_mispredict_i = 1; bus.ex_target_i = 32'h90;
                step();
                check("remp_pc", bus.pc_o, 32'h90);
                check("remp_flush1", 32'(bus.flush_o), 32'h1);
                idle();
            end
            step();
            check("flush2", 32'(bus.flush_o), 32'h1);
            check("flush2_valid", 32'(bus.fetch_valid_o), 32'h0);
            step();
            check("flush_end", 32'(bus.flush_o), 32'h0);
            check("flush_end_valid", 32'(bus.fetch_valid_o), 32'h1);
        end

        redirect(32'h300);
        resolve_branch(32'h40, 0);
        resolve_branch(32'h40, 0);
        redirect(32'h40);
        set_br(16);
`ifdef BHT_EN
        #1 check("bht_nt_pt", 32'(bus.predicted_taken_o), 32'h0);
        step();
        check("bht_nt_pc", bus.pc_o, 32'h44);
`else
        #1 check("br_pt", 32'(bus.predicted_taken_o), 32'h1);
        step();
        check("br_pc", bus.pc_o, 32'h50);
`endif
        for (int i = 0; i < 3; i++) resolve_branch(32'h40, 1);
        redirect(32'h40);
        set_br(16);
        #1 check("bht_t_pt", 32'(bus.predicted_taken_o), 32'h1);
        step();
        check("bht_t_pc", bus.pc_o, 32'h50);

        for (int c = 0; c < 3000; c++) begin
            rst_n = $urandom_range(0, 149) != 0;
            bus.stall_i = $urandom_range(0, 4) == 0;
            bus.inst_valid_i = $urandom_range(0, 7) != 0;
            set_rand_inst();
            bus.ex_resolve_valid_i = (mode == 2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
            bus.ex_mispredict_i = $urandom_range(0, 7) == 0;
            bus.ex_jalr_i = 1'($urandom_range(0, 1));
            bus.ex_is_branch_i = 1'($urandom_range(0, 1));
            bus.ex_taken_i = 1'($urandom_range(0, 1));
            bus.ex_pc_i = 32'($urandom_range(0, 127)) << 2;
            bus.ex_target_i = $urandom & 32'hFFFF_FFFC;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
- Owns the fetch PC register and selects the next-PC source each cycle.
- Sources are reset vector, execute-stage correction, JALR resolution, stall hold, predicted jump/branch, and sequential PC+4.
- Decodes JAL/B-type/JALR opcodes in fetch and forms the J/B targets.
- Sequences the JALR wait and mispredict flush windows, and drives the flush to downstream stages.

Parameters:
- size, 32, datapath/PC width
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset
- FLUSH_CYCLES, 2, cycles flush_o stays high after a redirect from execute (≥1)
- BHT_ENTRIES, 64, BHT depth (power of 2); used only with BHT_EN

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- stall_i  in  1  backend stall; hold PC
- inst_valid_i  in  1  inst_i is the instruction at pc_o
- inst_i  in  size  fetched instruction
- pc_o  out  size  current fetch PC (registered)
- fetch_valid_o  out  1  pc_o is a live fetch request
- predicted_taken_o  out  1  current instruction predicted redirecting (combinational)
- flush_o  out  1  kill younger in-flight instructions
- ex_resolve_valid_i  in  1  execute resolution strobe
- ex_is_branch_i  in  1  resolved op is B-type
- ex_jalr_i  in  1  resolved op is JALR
- ex_taken_i  in  1  actual branch outcome
- ex_mispredict_i  in  1  prediction was wrong
- ex_pc_i  in  size  PC of resolved op
- ex_target_i  in  size  correct next PC

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset (rst_n=0 at a clk edge):
  - pc_o=RESET_VECTOR, fetch_valid_o=0, flush_o=0, flush counter=0, state=BOOT.
  - predicted_taken_o=0 while state≠RUN.
  - Reset overrides every other input, including mid-flush and mid-JALR-wait.
- States: BOOT, RUN, JALR_WAIT, FLUSH.
- BOOT: next cycle goes to RUN. fetch_valid_o=1 from RUN onward.
- Decode of inst_i[6:0]: 1101111=JAL, 1100011=B-type, 1100111=JALR.
- Immediates, sign-extended to size:
  - J: {inst[31],inst[19:12],inst[20],inst[30:21],0}.
  - B: {inst[31],inst[7],inst[30:25],inst[11:8],0}.
- Target arithmetic: pc_o+imm and pc_o+4, both modulo 2^size. Wrap-around is silent.
- RUN, inst_valid_i=1, stall_i=0:
  - JAL, or B-type predicted taken: predicted_taken_o=1; pc_o←pc_o+imm next cycle.
  - JALR: pc_o held; fetch_valid_o=0; state→JALR_WAIT.
  - Otherwise: pc_o←pc_o+4.
- RUN with inst_valid_i=0: pc_o held, no prediction.
- stall_i=1 in RUN: pc_o and state held.
- JALR_WAIT:
  - On ex_resolve_valid_i & ex_jalr_i: pc_o←ex_target_i, state→RUN, fetch_valid_o=1 next cycle.
  - No flush is raised for a resolved JALR.
- Mispredict (ex_resolve_valid_i & ex_mispredict_i), valid in RUN, JALR_WAIT or FLUSH:
  - pc_o←ex_target_i; flush_o=1 and fetch_valid_o=0 for exactly FLUSH_CYCLES cycles starting next cycle; state FLUSH, then RUN.
  - A new mispredict inside FLUSH reloads the target and restarts the counter.
- Priority: reset > mispredict > JALR resolve > stall > prediction > sequential.
- A mispredict overrides stall_i in the same cycle.

Optional Feature:
- Macro: BHT_EN.
- Defined:
  - BHT_ENTRIES 2-bit saturating counters, indexed by pc[log2(BHT_ENTRIES)+1:2].
  - Reset value 2'b10 (weakly taken). B-type is predicted taken iff counter[1]=1.
  - Update on ex_resolve_valid_i & ex_is_branch_i at index from ex_pc_i: increment if ex_taken_i else decrement, saturating at 0 and 3.
  - Same-cycle lookup and update to the same index: the lookup sees the pre-update value.
- Not defined: no storage; every B-type is predicted taken; branch-resolve inputs are used only for mispredict.

Test Plan:
- Release rst_n with inst_i=NOP, inst_valid_i=1 → pc_o 0x0 (fetch_valid_o=0), then 0x0 (valid=1), then 0x4, 0x8.
- pc_o=0x100, inst_i=JAL imm=-8 → predicted_taken_o=1; next pc_o=0xF8; at pc_o=0xFFFF_FFFC, NOP → pc_o=0x0.
- JALR at 0x20 → fetch_valid_o=0 and pc_o held 5 cycles; resolve with ex_target_i=0x400 → pc_o=0x400, fetch_valid_o=1, flush_o never high.
- stall_i=1 plus mispredict with ex_target_i=0x80 in the same cycle → pc_o=0x80; flush_o high exactly 2 cycles; second mispredict (0x90) in cycle 1 of flush → pc_o=0x90, 2 more flush cycles.
- BHT_EN: resolve branch at 0x40 not-taken twice → next B-type at 0x40 predicted not-taken (pc_o+4); three taken resolves → counter=3, predicted taken.
